tdi_fsm_array: RTL and testbench
================================

TDI_FSM_ARRAY -- requirements
Module: tdi_fsm_array

Interface
REQ-001 SHALL have parameter NUM_TDI, default 4: number of independent TDI state machines (1..16).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 255: cycles a TDI may remain in LOCK (timeout build only).
REQ-003 SHALL have parameter TW = $clog2(NUM_TDI) (minimum 1): width of req_tdi.
REQ-004 clk  in  1  sole clock; all flops on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 req_valid  in  1  command request.
REQ-007 req_tdi  in  TW  target TDI index.
REQ-008 req_op  in  2  command: 00 LOCK, 01 START, 10 STOP, 11 RECOVER.
REQ-009 req_ready  out  1  command may be accepted.
REQ-010 rsp_valid  out  1  one-cycle response strobe.
REQ-011 rsp_status  out  2  00 OK, 01 ILLEGAL, 10 PRECOND_FAIL, 11 ABORTED.
REQ-012 auth_complete  in  NUM_TDI  per-TDI SPDM authentication done.
REQ-013 ide_active  in  NUM_TDI  per-TDI IDE stream established.
REQ-014 security_violation  in  NUM_TDI  per-TDI violation.
REQ-015 tdi_state  out  2*NUM_TDI  packed states, TDI i at [2i+1:2i]; 00 CONFIG, 01 LOCK, 10 RUN, 11 ERROR.
REQ-016 tdi_run  out  NUM_TDI  bit i high iff TDI i in RUN.
REQ-017 err_vec  out  NUM_TDI  sticky per-TDI error flags.
REQ-018 err_irq  out  1  one-cycle pulse when any TDI enters ERROR.

Function
REQ-019 Handshake: command accepted on a rising edge where req_valid && req_ready; req_ready SHALL equal !rsp_valid.
REQ-020 Accepted command SHALL update state and raise rsp_valid with rsp_status on the next edge (latency 1); rsp_valid SHALL last exactly one cycle.
REQ-021 LOCK: CONFIG->LOCK if auth_complete[i], else PRECOND_FAIL; from any other state ILLEGAL, no change.
REQ-022 START: LOCK->RUN if ide_active[i], else PRECOND_FAIL; from other states ILLEGAL.
REQ-023 STOP: RUN->CONFIG or LOCK->CONFIG with OK; from CONFIG or ERROR ILLEGAL.
REQ-024 RECOVER: ERROR->CONFIG with OK and err_vec[i] cleared if security_violation[i] low, else PRECOND_FAIL; from other states ILLEGAL.
REQ-025 req_tdi >= NUM_TDI SHALL return ILLEGAL with no state change.
REQ-026 CONFIG->RUN direct SHALL never occur.
REQ-027 security_violation[i] high at an edge SHALL force TDI i to ERROR on that edge from any state, including ERROR.
REQ-028 In LOCK or RUN, auth_complete[i] low SHALL force ERROR; in RUN, ide_active[i] low SHALL force ERROR.
REQ-029 Forced ERROR SHALL take priority over a same-edge command to the same TDI; that command SHALL respond ABORTED.
REQ-030 Each ERROR entry from a non-ERROR state SHALL set err_vec[i] and pulse err_irq for one cycle; simultaneous entries on several TDIs SHALL produce one pulse.
REQ-031 Commands and forced errors on different TDIs in the same cycle SHALL proceed independently.

Reset
REQ-032 While rst_n low: all TDIs CONFIG; tdi_run, err_vec, err_irq, rsp_valid, rsp_status = 0; req_ready = 1.
REQ-033 Reset asserted mid-command SHALL drop the pending response; no rsp_valid after reset release.

Configuration
REQ-034 With TDI_LOCK_TIMEOUT_EN defined: a per-TDI counter SHALL clear on LOCK entry and increment each cycle in LOCK; when the count equals LOCK_TIMEOUT, the TDI SHALL enter ERROR on the next edge, following REQ-029/REQ-030.
REQ-035 Without TDI_LOCK_TIMEOUT_EN: no counters exist, LOCK_TIMEOUT is ignored, and LOCK persists indefinitely.

Verification
REQ-036 TDI0 with auth=1: LOCK -> OK, state 01; ide=1, START -> OK, state 10, tdi_run[0]=1; STOP -> OK, state 00.
REQ-037 TDI1 in CONFIG: START -> ILLEGAL, state stays 00; LOCK with auth=0 -> PRECOND_FAIL.
REQ-038 TDI2 in RUN, violation[2] pulsed with a STOP to TDI2 on the same edge -> state 11, ABORTED, err_vec[2]=1, single err_irq; RECOVER with violation=0 -> OK, err_vec[2]=0.
REQ-039 Violation on TDI0 and TDI3 on the same edge -> both ERROR, one err_irq pulse; req_tdi=5 with NUM_TDI=4 -> ILLEGAL.
REQ-040 With TDI_LOCK_TIMEOUT_EN defined and LOCK_TIMEOUT=10: TDI0 held in LOCK with ide=0 -> ERROR 11 cycles after LOCK entry; without the macro -> still LOCK after 1000 cycles.

Source files
------------

// File: rtl/tdi_fsm_array.sv
// Array of NUM_TDI independent TDI lifecycle FSMs behind one command/response port.
// Define TDI_LOCK_TIMEOUT_EN to bound the time a TDI may stay in LOCK (LOCK_TIMEOUT cycles).
package tdi_fsm_pkg;
  typedef enum logic [1:0] {S_CONFIG = 2'b00, S_LOCK = 2'b01, S_RUN = 2'b10, S_ERROR = 2'b11} tdi_st_e;
  typedef enum logic [1:0] {OP_LOCK = 2'b00, OP_START = 2'b01, OP_STOP = 2'b10, OP_RECOVER = 2'b11} tdi_op_e;
  typedef enum logic [1:0] {RSP_OK = 2'b00, RSP_ILLEGAL = 2'b01, RSP_PRECOND = 2'b10, RSP_ABORTED = 2'b11} tdi_rsp_e;
endpackage

module tdi_lane
  import tdi_fsm_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     cmd_en,
  input  tdi_op_e  op,
  input  logic     auth,
  input  logic     ide,
  input  logic     viol,
  output tdi_st_e  st,
  output logic     err_flag,
  output logic     err_enter,
  output tdi_rsp_e status
);
  logic     tmo, force_err, err_clr;
  tdi_st_e  cmd_nxt;
  tdi_rsp_e cmd_rsp;

`ifdef TDI_LOCK_TIMEOUT_EN
  localparam int CW = (LOCK_TIMEOUT < 1) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  logic [CW-1:0] lock_cnt;
  // Counter idles at zero outside LOCK, so it reads zero on the entry edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             lock_cnt <= '0;
    else if (st != S_LOCK)  lock_cnt <= '0;
    else                    lock_cnt <= lock_cnt + CW'(1);
  end
  assign tmo = (st == S_LOCK) && (lock_cnt == CW'(LOCK_TIMEOUT));
`else
  assign tmo = 1'b0;
`endif

  // In ERROR the only forcing source is a violation, which keeps the lane in ERROR.
  assign force_err = viol | tmo
                   | (((st == S_LOCK) || (st == S_RUN)) && !auth)
                   | ((st == S_RUN) && !ide);
  assign err_enter = force_err && (st != S_ERROR);

  always_comb begin
    cmd_rsp = RSP_ILLEGAL;
    cmd_nxt = st;
    case (op)
      OP_LOCK:
        if (st == S_CONFIG) begin
          if (auth) begin cmd_rsp = RSP_OK; cmd_nxt = S_LOCK; end
          else            cmd_rsp = RSP_PRECOND;
        end
      OP_START:
        if (st == S_LOCK) begin
          if (ide) begin cmd_rsp = RSP_OK; cmd_nxt = S_RUN; end
          else           cmd_rsp = RSP_PRECOND;
        end
      OP_STOP:
        if ((st == S_RUN) || (st == S_LOCK)) begin
          cmd_rsp = RSP_OK;
          cmd_nxt = S_CONFIG;
        end
      OP_RECOVER:
        if (st == S_ERROR) begin
          if (!viol) begin cmd_rsp = RSP_OK; cmd_nxt = S_CONFIG; end
          else            cmd_rsp = RSP_PRECOND;
        end
      default: ;
    endcase
  end

  assign status  = !cmd_en ? RSP_OK : (err_enter ? RSP_ABORTED : cmd_rsp);
  assign err_clr = cmd_en && !force_err && (op == OP_RECOVER) && (cmd_rsp == RSP_OK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_CONFIG;
      err_flag <= 1'b0;
    end else begin
      if (force_err)   st <= S_ERROR;
      else if (cmd_en) st <= cmd_nxt;
      if (err_enter)    err_flag <= 1'b1;
      else if (err_clr) err_flag <= 1'b0;
    end
  end
endmodule

module tdi_fsm_array
  import tdi_fsm_pkg::*;
#(
  parameter int NUM_TDI      = 4,
  parameter int LOCK_TIMEOUT = 255,
  parameter int TW           = (NUM_TDI > 1) ? $clog2(NUM_TDI) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic [TW-1:0]        req_tdi,
  input  logic [1:0]           req_op,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_status,
  input  logic [NUM_TDI-1:0]   auth_complete,
  input  logic [NUM_TDI-1:0]   ide_active,
  input  logic [NUM_TDI-1:0]   security_violation,
  output logic [2*NUM_TDI-1:0] tdi_state,
  output logic [NUM_TDI-1:0]   tdi_run,
  output logic [NUM_TDI-1:0]   err_vec,
  output logic                 err_irq
);
  logic                      accept, in_range;
  logic [NUM_TDI-1:0]        hit, enter;
  tdi_rsp_e [NUM_TDI-1:0]    lane_rsp;
  tdi_st_e  [NUM_TDI-1:0]    lane_st;
  logic [1:0]                rsp_or;

  assign req_ready = !rsp_valid;
  assign accept    = req_valid && req_ready;
  assign in_range  = int'(req_tdi) < NUM_TDI;

  for (genvar i = 0; i < NUM_TDI; i++) begin : g_lane
    assign hit[i] = accept && in_range && (req_tdi == TW'(i));
    tdi_lane #(.LOCK_TIMEOUT(LOCK_TIMEOUT)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_en    (hit[i]),
      .op        (tdi_op_e'(req_op)),
      .auth      (auth_complete[i]),
      .ide       (ide_active[i]),
      .viol      (security_violation[i]),
      .st        (lane_st[i]),
      .err_flag  (err_vec[i]),
      .err_enter (enter[i]),
      .status    (lane_rsp[i])
    );
    assign tdi_state[2*i +: 2] = lane_st[i];
    assign tdi_run[i]          = (lane_st[i] == S_RUN);
  end

  // Idle lanes report RSP_OK (zero), so OR-ing picks out the addressed lane.
  always_comb begin
    rsp_or = 2'b00;
    for (int i = 0; i < NUM_TDI; i++) rsp_or = rsp_or | lane_rsp[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_status <= 2'b00;
      err_irq    <= 1'b0;
    end else begin
      rsp_valid  <= accept;
      rsp_status <= !accept ? 2'b00 : (in_range ? rsp_or : RSP_ILLEGAL);
      err_irq    <= |enter;
    end
  end
endmodule

// File: tb/tb_tdi_fsm_array.sv
// Directed bench for tdi_fsm_array (NUM_TDI=4, LOCK_TIMEOUT=10, TW=3 so out-of-range indices are reachable).
module tb_tdi_fsm_array;
  localparam int N = 4;
  localparam logic [1:0] LOCK = 2'b00, START = 2'b01, STOP = 2'b10, RECOVER = 2'b11;
  localparam logic [1:0] OK = 2'b00, ILL = 2'b01, PRE = 2'b10, ABT = 2'b11;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, rsp_valid, err_irq;
  logic [2:0] req_tdi = '0;
  logic [1:0] req_op = '0, rsp_status, st;
  logic [N-1:0] auth = '0, ide = '0, viol = '0, tdi_run, err_vec;
  logic [2*N-1:0] tdi_state;
  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  tdi_fsm_array #(.NUM_TDI(N), .LOCK_TIMEOUT(10), .TW(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_tdi(req_tdi), .req_op(req_op),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .auth_complete(auth), .ide_active(ide), .security_violation(viol),
    .tdi_state(tdi_state), .tdi_run(tdi_run), .err_vec(err_vec), .err_irq(err_irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_ready", req_ready, 1);
  endtask

  task automatic cmd(input logic [2:0] tdi, input logic [1:0] op, output logic [1:0] s);
    wait_ready();
    req_valid = 1'b1; req_tdi = tdi; req_op = op;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rsp_valid", rsp_valid, 1);
    s = rsp_status;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    chk("rst_state", tdi_state, 0);
    chk("rst_run", tdi_run, 0);
    chk("rst_err", err_vec, 0);
    chk("rst_irq", err_irq, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rsps", rsp_status, 0);
    chk("rst_ready", req_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    auth = 4'b1101; ide = 4'b1101;
    tick();

    // TDI0 normal lifecycle
    cmd(0, LOCK, st);  chk("t0_lock", st, OK);   chk("t0_lock_st", tdi_state[1:0], 2'b01);
    tick(); chk("rsp_one_cycle", rsp_valid, 0);
    cmd(0, START, st); chk("t0_start", st, OK);  chk("t0_run_st", tdi_state[1:0], 2'b10);
    chk("t0_run_bit", tdi_run, 4'b0001);
    cmd(0, STOP, st);  chk("t0_stop", st, OK);   chk("t0_stop_st", tdi_state[1:0], 2'b00);

    // TDI1 illegal and precondition paths
    cmd(1, START, st); chk("t1_start_ill", st, ILL); chk("t1_st", tdi_state[3:2], 2'b00);
    cmd(1, LOCK, st);  chk("t1_lock_pre", st, PRE);  chk("t1_st2", tdi_state[3:2], 2'b00);
    cmd(1, RECOVER, st); chk("t1_recover_ill", st, ILL);

    // TDI2: violation beats same-edge STOP
    cmd(2, LOCK, st);  chk("t2_lock", st, OK);
    cmd(2, START, st); chk("t2_start", st, OK); chk("t2_run", tdi_state[5:4], 2'b10);
    wait_ready();
    req_valid = 1'b1; req_tdi = 3'd2; req_op = STOP; viol = 4'b0100;
    @(posedge clk); #1;
    req_valid = 1'b0; viol = '0;
    chk("t2_abort_v", rsp_valid, 1);
    chk("t2_abort", rsp_status, ABT);
    chk("t2_err_st", tdi_state[5:4], 2'b11);
    chk("t2_errvec", err_vec, 4'b0100);
    chk("t2_irq", err_irq, 1);
    tick(); chk("t2_irq_once", err_irq, 0);
    cmd(2, START, st); chk("t2_start_err_ill", st, ILL);
    cmd(2, RECOVER, st); chk("t2_recover", st, OK);
    chk("t2_errvec_clr", err_vec, 4'b0000); chk("t2_cfg", tdi_state[5:4], 2'b00);

    // Simultaneous violations on TDI0 and TDI3, then out-of-range index
    viol = 4'b1001; tick(); viol = '0;
    chk("v03_state", {tdi_state[7:6], tdi_state[1:0]}, 4'b1111);
    chk("v03_errvec", err_vec, 4'b1001);
    chk("v03_irq", err_irq, 1);
    tick(); chk("v03_irq_once", err_irq, 0);
    cmd(5, LOCK, st); chk("oor_ill", st, ILL); chk("oor_state", tdi_state, 8'hC3);
    viol = 4'b1000;
    cmd(3, RECOVER, st); chk("t3_recover_pre", st, PRE);
    viol = '0;
    cmd(3, RECOVER, st); chk("t3_recover", st, OK);
    cmd(0, RECOVER, st); chk("t0_recover", st, OK);
    chk("all_cfg", tdi_state, 0); chk("errvec_clear", err_vec, 0);

    // Independent lanes: TDI3 LOCK while TDI0 takes a violation
    wait_ready();
    req_valid = 1'b1; req_tdi = 3'd3; req_op = LOCK; viol = 4'b0001;
    @(posedge clk); #1;
    req_valid = 1'b0; viol = '0;
    chk("indep_rsp", rsp_status, OK);
    chk("indep_state", tdi_state, 8'h43);
    cmd(0, RECOVER, st); chk("indep_rec", st, OK);

    // auth drop in LOCK forces ERROR
    auth[3] = 1'b0; tick();
    chk("auth_drop", tdi_state[7:6], 2'b11); chk("auth_irq", err_irq, 1);
    auth[3] = 1'b1;
    cmd(3, RECOVER, st); chk("t3_rec2", st, OK);

    // ide drop in RUN forces ERROR
    cmd(0, LOCK, st); cmd(0, START, st); chk("t0_run2", tdi_state[1:0], 2'b10);
    ide[0] = 1'b0; tick();
    chk("ide_drop", tdi_state[1:0], 2'b11); chk("ide_errvec", err_vec, 4'b0001);
    cmd(0, RECOVER, st); chk("t0_rec3", st, OK);

    // Reset in the middle of a response
    wait_ready();
    req_valid = 1'b1; req_tdi = 3'd1; req_op = STOP;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_rspv_pre", rsp_valid, 1);
    rst_n = 1'b0; #1;
    chk("mid_rspv", rsp_valid, 0); chk("mid_ready", req_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    tick(); chk("mid_no_rsp", rsp_valid, 0);

    // LOCK timeout with ide low (ide irrelevant in LOCK)
    cmd(0, LOCK, st); chk("tmo_lock", st, OK);
`ifdef TDI_LOCK_TIMEOUT_EN
    repeat (10) @(posedge clk); #1;
    chk("tmo_still_lock", tdi_state[1:0], 2'b01);
    tick();
    chk("tmo_err", tdi_state[1:0], 2'b11);
    chk("tmo_irq", err_irq, 1);
    chk("tmo_errvec", err_vec[0], 1);
`else
    repeat (1000) @(posedge clk); #1;
    chk("no_tmo_lock", tdi_state[1:0], 2'b01);
    chk("no_tmo_errvec", err_vec, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
